// File: rtl/fec_pkg.sv
// Shared Hamming(7,4) types and helpers; codeword bit i-1 holds Hamming position i (p1 p2 d1 p3 d2 d3 d4).
// Pure combinational functions, no latency, no flow control.
package fec_pkg;
    localparam int K = 4;
    localparam int N = 7;

    typedef logic [K-1:0] data_t;
    typedef logic [N-1:0] cw_t;

    function automatic cw_t hamming_enc(input data_t d);
        cw_t cw;
        cw[0] = d[0] ^ d[1] ^ d[3];
        cw[1] = d[0] ^ d[2] ^ d[3];
        cw[2] = d[0];
        cw[3] = d[1] ^ d[2] ^ d[3];
        cw[4] = d[1];
        cw[5] = d[2];
        cw[6] = d[3];
        return cw;
    endfunction

    // Result is the 1-based position of a single flipped bit, 0 when clean.
    function automatic logic [2:0] hamming_syndrome(input cw_t cw);
        logic [2:0] s;
        s[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        s[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        s[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        return s;
    endfunction
endpackage

// File: rtl/hamming74_dec.sv
// Registered Hamming(7,4) decoder correcting any single-bit error.
// One cycle latency, accepts a codeword every cycle, no back-pressure.
module hamming74_dec
    import fec_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cw_valid,
    input  logic [6:0] cw,
    output logic       data_valid,
    output logic [3:0] data,
    output logic [2:0] syndrome
);
    logic [2:0] syn;
    logic [6:0] fixed;

    always_comb begin
        syn   = hamming_syndrome(cw);
        fixed = cw ^ ((syn != 3'd0) ? (7'd1 << (syn - 3'd1)) : 7'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid <= 1'b0;
            data       <= '0;
            syndrome   <= '0;
        end else begin
            data_valid <= cw_valid;
            data       <= {fixed[6], fixed[5], fixed[4], fixed[2]};
            syndrome   <= syn;
        end
    end
endmodule

// File: rtl/fec_top.sv
// FEC demonstrator: counter source -> Hamming encoder -> single-bit-error channel -> decoder -> monitor.
// Source to decoded word is 3 cycles after the source register, one word per cycle, no back-pressure.
module fec_top
    import fec_pkg::*;
#(
    parameter bit INJECT = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_dv
);
    logic [3:0]       cnt;
    logic             src_valid;
    logic [3:0]       src_data;
    logic             enc_valid;
    logic [6:0]       enc_cw;
    logic [2:0]       flip_pos;
    logic [6:0]       flip_mask;
    logic             ch_valid;
    logic [6:0]       ch_cw;
    logic             dec_valid;
    logic [3:0]       dec_data;
    logic [2:0]       dec_syn;
    logic [3:0]       ref_d0;
    logic [3:0]       ref_d1;
    logic [3:0]       ref_d2;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] err_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt       <= '0;
            src_data  <= '0;
            src_valid <= 1'b0;
        end else begin
            src_valid <= i_dv;
            if (i_dv) begin
                src_data <= cnt;
                cnt      <= cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            enc_cw    <= '0;
            enc_valid <= 1'b0;
        end else begin
            enc_cw    <= hamming_enc(src_data);
            enc_valid <= src_valid;
        end
    end

    // The error position only moves on real words so bubbles do not skew the pattern.
    assign flip_mask = INJECT ? (7'd1 << flip_pos) : 7'd0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ch_cw    <= '0;
            ch_valid <= 1'b0;
            flip_pos <= '0;
        end else begin
            ch_cw    <= enc_cw ^ flip_mask;
            ch_valid <= enc_valid;
            if (enc_valid)
                flip_pos <= (flip_pos == 3'd6) ? 3'd0 : flip_pos + 3'd1;
        end
    end

    hamming74_dec u_dec (
        .clk        (i_clk),
        .rst        (i_rst),
        .cw_valid   (ch_valid),
        .cw         (ch_cw),
        .data_valid (dec_valid),
        .data       (dec_data),
        .syndrome   (dec_syn)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ref_d0    <= '0;
            ref_d1    <= '0;
            ref_d2    <= '0;
            frame_cnt <= '0;
            corr_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            ref_d0 <= src_data;
            ref_d1 <= ref_d0;
            ref_d2 <= ref_d1;
            if (dec_valid) begin
                if (frame_cnt != '1)
                    frame_cnt <= frame_cnt + CNT_W'(1);
                if (dec_syn != 3'd0 && corr_cnt != '1)
                    corr_cnt <= corr_cnt + CNT_W'(1);
                if (dec_data != ref_d2 && err_cnt != '1)
                    err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fec_top.sv
// Scoreboarded bench for fec_top: one injecting instance and one transparent, narrow-counter instance.
module tb_fec_top;
    logic clk = 1'b0;
    logic rst;
    logic dv;

    always #5 clk = ~clk;

    fec_top #(.INJECT(1'b1), .CNT_W(16)) top   (.i_clk(clk), .i_rst(rst), .i_dv(dv));
    fec_top #(.INJECT(1'b0), .CNT_W(4))  clean (.i_clk(clk), .i_rst(rst), .i_dv(dv));

    typedef struct {
        logic [3:0] d;
        int         flip;
        int         cyc;
    } exp_t;

    exp_t src_q[$];
    exp_t enc_q[$];
    exp_t ch_q[$];
    exp_t dec_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_cnt;
    int model_flip;
    int model_frames;

    always @(posedge clk) cyc <= cyc + 1;

    // Generic Hamming construction: data fills non-power-of-two positions, each
    // parity position 2^b covers every position whose index has bit b set.
    function automatic logic [6:0] ref_enc(input logic [3:0] d);
        logic [6:0] cw;
        logic       par;
        int         k;
        cw = '0;
        k  = 0;
        for (int p = 1; p <= 7; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 3; b++) begin
            par = 1'b0;
            for (int p = 1; p <= 7; p++)
                if ((p & (1 << b)) != 0 && p != (1 << b))
                    par = par ^ cw[p-1];
            cw[(1 << b) - 1] = par;
        end
        return cw;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s got valid with nothing outstanding at cycle %0d", name, cyc);
    endtask

    task automatic model_reset();
        src_q.delete();
        enc_q.delete();
        ch_q.delete();
        dec_q.delete();
        model_cnt    = 0;
        model_flip   = 0;
        model_frames = 0;
    endtask

    task automatic step(input bit v);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b0;
        dv  = v;
        if (v) begin
            e.d  = 4'(model_cnt);
            e.flip = model_flip;
            e.cyc  = cyc;
            src_q.push_back(e);
            enc_q.push_back(e);
            ch_q.push_back(e);
            dec_q.push_back(e);
            model_cnt  = (model_cnt + 1) % 16;
            model_flip = (model_flip + 1) % 7;
            model_frames++;
        end
    endtask

    task automatic reset_pulse(input bit v);
        @(posedge clk);
        #1;
        rst = 1'b1;
        dv  = v;
        model_reset();
        #1;
        check("rst_frame_cnt", top.frame_cnt, 0);
        check("rst_corr_cnt", top.corr_cnt, 0);
        check("rst_err_cnt", top.err_cnt, 0);
        check("rst_clean_frame_cnt", clean.frame_cnt, 0);
    endtask

    task automatic check_counters();
        int sat;
        sat = (model_frames > 15) ? 15 : model_frames;
        check("frame_cnt", top.frame_cnt, model_frames);
        check("corr_cnt", top.corr_cnt, model_frames);
        check("err_cnt", top.err_cnt, 0);
        check("clean_frame_cnt", clean.frame_cnt, sat);
        check("clean_corr_cnt", clean.corr_cnt, 0);
        check("clean_err_cnt", clean.err_cnt, 0);
    endtask

    // Monitor: pops the scoreboard whenever a stage presents a word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (top.src_valid || clean.src_valid) begin
                if (src_q.size() == 0) unexpected("src_valid");
                else begin
                    e = src_q.pop_front();
                    check("src_valid", {31'd0, top.src_valid}, 1);
                    check("src_data", top.src_data, e.d);
                    check("src_lat", cyc, e.cyc + 1);
                end
            end
            if (top.enc_valid || clean.enc_valid) begin
                if (enc_q.size() == 0) unexpected("enc_valid");
                else begin
                    e = enc_q.pop_front();
                    check("enc_cw", top.enc_cw, ref_enc(e.d));
                    check("enc_lat", cyc, e.cyc + 2);
                    if (e.d == 4'd11) check("enc_1011", top.enc_cw, 7'b1010101);
                    if (e.d == 4'd0)  check("enc_0000", top.enc_cw, 7'b0000000);
                end
            end
            if (top.ch_valid || clean.ch_valid) begin
                if (ch_q.size() == 0) unexpected("ch_valid");
                else begin
                    e = ch_q.pop_front();
                    check("ch_cw", top.ch_cw, ref_enc(e.d) ^ (7'd1 << e.flip));
                    check("clean_ch_cw", clean.ch_cw, ref_enc(e.d));
                    check("ch_lat", cyc, e.cyc + 3);
                end
            end
            if (top.dec_valid || clean.dec_valid) begin
                if (dec_q.size() == 0) unexpected("dec_valid");
                else begin
                    e = dec_q.pop_front();
                    check("dec_valid", {30'd0, top.dec_valid, clean.dec_valid}, 3);
                    check("dec_data", top.dec_data, e.d);
                    check("clean_dec_data", clean.dec_data, e.d);
                    check("dec_lat", cyc, e.cyc + 4);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        dv  = 1'b1;
        model_reset();
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_valids", {28'd0, top.src_valid, top.enc_valid, top.ch_valid, top.dec_valid}, 0);
        check("reset_src_data", top.src_data, 0);
        check("reset_ch_cw", top.ch_cw, 0);
        check("reset_dec_data", top.dec_data, 0);
        check("reset_frame_cnt", top.frame_cnt, 0);

        repeat (4) step(1'b0);
        check("idle_frame_cnt", top.frame_cnt, 0);

        repeat (12) step(1'b1);
        repeat (6) step(1'b0);
        check_counters();

        reset_pulse(1'b0);
        repeat (20) step(1'b1);
        repeat (6) step(1'b0);
        check_counters();

        reset_pulse(1'b0);
        repeat (5) step(1'b1);
        reset_pulse(1'b1);
        repeat (9) step(1'b1);
        repeat (6) step(1'b0);
        check_counters();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) reset_pulse(1'($urandom_range(0, 1)));
            else step($urandom_range(0, 3) != 0);
        end
        repeat (6) step(1'b0);
        check_counters();

        check("leftover_src", src_q.size(), 0);
        check("leftover_dec", dec_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fec_top.md
# fec_top

Self-contained FEC demonstrator and top level of the hardware chain, instantiated in the design as `top`. A gated counter source produces 4-bit words. Each word is Hamming(7,4)-encoded, passed through a deterministic single-bit-error channel, then decoded and corrected. A monitor compares each decoded word with the transmitted word. The top has no output ports, so benches observe results through the named internal signals listed below.

## Interface
- `INJECT`, default 1: when 1, the channel flips exactly one bit per codeword. When 0, the channel is transparent.
- `CNT_W`, default 16: width of the monitor counters.
- `i_clk`, input, 1: single clock, rising edge.
- `i_rst`, input, 1: asynchronous, active-high reset.
- `i_dv`, input, 1: data-valid / enable for the source. One word is produced per cycle while high.
- No other ports; the port list is exactly these three.
- Mandatory internal signals, visible to the bench:
  - 1-bit valids: `src_valid`, `enc_valid`, `ch_valid`, `dec_valid`.
  - 4-bit data: `src_data`, `dec_data`.
  - 7-bit codewords: `enc_cw`, `ch_cw`.
  - `CNT_W`-bit counters: `frame_cnt`, `corr_cnt`, `err_cnt`.

## Operation
- **Source:**
  - A 4-bit counter `cnt` starts at 0.
  - On each edge with `i_dv`=1: `src_data<=cnt`, `src_valid<=1`, `cnt<=cnt+1`. The counter wraps from 15 to 0.
  - On edges with `i_dv`=0: `src_valid<=0`, and `cnt` and `src_data` hold.
- **Encoder (registered):**
  - Data bits d1..d4 = `src_data[0..3]`.
  - Codeword bit `cw[i-1]` is Hamming position i, in the order p1 p2 d1 p3 d2 d3 d4.
  - Parities: p1=d1^d2^d4, p2=d1^d3^d4, p3=d2^d3^d4.
  - `enc_valid` follows `src_valid`.
- **Channel (registered):**
  - `ch_cw <= enc_cw ^ (INJECT ? 1<<flip_pos : 0)`.
  - `flip_pos` is a 3-bit register that cycles 0,1,…,6,0 and advances only on cycles with `enc_valid`=1.
  - `ch_valid` follows `enc_valid`.
- **Decoder (registered):**
  - Syndrome bits: s1 = parity of positions {1,3,5,7}, s2 = parity of {2,3,6,7}, s3 = parity of {4,5,6,7}.
  - S={s3,s2,s1}. If S≠0, flip position S, then extract d1..d4 into `dec_data`.
  - `dec_valid` follows `ch_valid`.
- **Monitor:**
  - A 3-deep delay line aligns `src_data` with `dec_data`.
  - On each `dec_valid`: `frame_cnt++`; `corr_cnt++` if S≠0; `err_cnt++` if `dec_data` ≠ aligned reference.
  - All three counters saturate at all-ones.
- With any `INJECT` setting, `err_cnt` must remain 0, because at most one bit is flipped per codeword.

## Timing
- Reset, asynchronous: every register clears to 0. This covers `cnt`, all data and codeword registers, all valids, `flip_pos`, the delay line and the counters.
- Latency: `i_dv` is sampled at edge E. Then:
  - `src_valid` rises after E.
  - `enc_valid` rises after E+1.
  - `ch_valid` rises after E+2.
  - `dec_valid` rises after E+3.
- Throughput: one word per cycle, no back-pressure, no stalls. Gaps in `i_dv` propagate unchanged as bubbles.
- Reset asserted mid-burst: in-flight words are discarded and the counters clear. After release, the source restarts at 0 and `flip_pos` restarts at 0.
- `i_dv` asserted during reset is ignored.

## Structure
- Package `fec_pkg`:
  - constants K=4, N=7;
  - typedefs `data_t` (4 bits) and `cw_t` (7 bits);
  - functions `hamming_enc` and `hamming_syndrome`.
- The design is a single top plus one natural sub-module, `hamming74_dec`: a registered decoder with outputs for the corrected data, the syndrome and the valid. The source, encoder, channel and monitor stay inline in the top.

## Test plan
- Reset, then 4 idle cycles with `i_dv`=0:
  - all valids stay 0;
  - `frame_cnt`=0.
- Burst of 12 cycles with `i_dv`=1:
  - `dec_valid` is high for 12 consecutive cycles, starting 3 cycles after `src_valid`;
  - `dec_data` = 0..11 in order;
  - `frame_cnt`=12, `corr_cnt`=12, `err_cnt`=0.
- Same burst with `INJECT`=0:
  - `ch_cw`==`enc_cw` for every frame;
  - `corr_cnt`=0, `err_cnt`=0.
- Encoder spot check:
  - `src_data`=4'b1011 gives `enc_cw`=7'b1010101 (d1=1, d2=1, d3=0, d4=1, so p1=1, p2=0, p3=0).
  - `src_data`=0 gives `enc_cw`=0.
- Burst of 20 words:
  - source wraps 15→0, with `dec_data` sequence …14,15,0,1,2,3;
  - `flip_pos` cycles through 0..6.
- Reset asserted for 1 cycle after 5 words of a burst, with `i_dv` held high:
  - counters read 0 immediately;
  - the next `dec_data` sequence starts at 0.
